// File: rtl/issue_arbiter_if.sv
// rtl/issue_arbiter_if.sv - issue port bundle between issue buffers, arbiter and functional unit
//
// Purpose: carries the requester-side and functional-unit-side handshakes of
//          issue_arbiter as one bundle.
// Signals:
//   req_data    [REQUESTERS*DATA_WIDTH] packed ops, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid   [REQUESTERS]            requester i holds an issuable op
//   req_ready   [REQUESTERS]            one-hot (or zero) consume strobe
//   out_data    [DATA_WIDTH]            registered op to the functional unit
//   out_grant   [IDX_W]                 requester that supplied out_data
//   out_valid                           out_data holds a valid op
//   out_ready                           functional unit accepts out_data
//   busy_cycles [16]                    saturating stall-cycle count
// Modports: slave = arbiter side, master = environment side.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 8
`endif

interface issue_arbiter_if #(
  parameter int DATA_WIDTH = `RENAMED_OP_SZ,
  parameter int REQUESTERS = 4
);
  localparam int IDX_W = $clog2(REQUESTERS);

  logic [REQUESTERS*DATA_WIDTH-1:0] req_data;
  logic [REQUESTERS-1:0]            req_valid;
  logic [REQUESTERS-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [IDX_W-1:0]                 out_grant;
  logic                             out_valid;
  logic                             out_ready;
  logic [15:0]                      busy_cycles;

  modport slave (
    input  req_data, req_valid, out_ready,
    output req_ready, out_data, out_grant, out_valid, busy_cycles
  );

  modport master (
    output req_data, req_valid, out_ready,
    input  req_ready, out_data, out_grant, out_valid, busy_cycles
  );
endinterface

// File: rtl/issue_arbiter.sv
// rtl/issue_arbiter.sv - round-robin arbiter feeding one functional-unit issue port
//
// Purpose: picks one of REQUESTERS issue buffers per cycle (round-robin from
//          ptr) and registers its op into a single-entry output stage. The
//          stage reloads on the same edge it drains, so an always-ready unit
//          sees one op per cycle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  issue_arbiter_if.slave (requester handshakes, output stage, stall count)
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 8
`endif

module issue_arbiter #(
  parameter int DATA_WIDTH = `RENAMED_OP_SZ,
  parameter int REQUESTERS = 4
) (
  input logic          clk,
  input logic          rst,
  issue_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(REQUESTERS);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] ptr_next;
  logic             any_req;
  logic             load_en;

  assign any_req = |bus.req_valid;
  assign load_en = !bus.out_valid || bus.out_ready;

  // First valid requester at or after ptr, wrapping modulo REQUESTERS.
  // Scanning from the farthest candidate back to ptr lets the closest win.
  always_comb begin
    int cand;
    sel  = ptr;
    cand = 0;
    for (int k = REQUESTERS - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % REQUESTERS;
      if (bus.req_valid[cand]) sel = IDX_W'(cand);
    end
  end

  // Explicit wrap keeps ptr below REQUESTERS for non-power-of-2 counts.
  assign ptr_next = (int'(sel) == REQUESTERS - 1) ? '0 : sel + IDX_W'(1);

  // Gated by rst so nothing is consumed while reset is held.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      bus.req_ready[i] = rst && load_en && any_req && (int'(sel) == i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_grant <= '0;
    end else if (load_en) begin
      if (any_req) begin
        bus.out_data  <= bus.req_data[sel*DATA_WIDTH +: DATA_WIDTH];
        bus.out_grant <= sel;
        bus.out_valid <= 1'b1;
        ptr           <= ptr_next;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.busy_cycles <= '0;
    end else if (bus.out_valid && !bus.out_ready && bus.busy_cycles != 16'hFFFF) begin
      bus.busy_cycles <= bus.busy_cycles + 16'd1;
    end
  end
endmodule

// File: tb/tb_issue_arbiter.sv
// tb/tb_issue_arbiter.sv - directed table-driven bench for issue_arbiter
module tb_issue_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  issue_arbiter_if #(.DATA_WIDTH(8), .REQUESTERS(4)) bus ();

  issue_arbiter #(.DATA_WIDTH(8), .REQUESTERS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_ovalid;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_data;
    logic [15:0] exp_busy;
  } vec_t;

  vec_t vecs[64];
  int   nvec;

  localparam logic [31:0] D = 32'hA3A2A1A0;

  task automatic add(input logic [3:0] v, input logic [31:0] d, input logic r,
                     input logic [3:0] er, input logic ev, input logic [1:0] eg,
                     input logic [7:0] ed, input logic [15:0] eb);
    vecs[nvec] = '{v, d, r, er, ev, eg, ed, eb};
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n);
    @(negedge clk);
    bus.req_valid = vecs[n].valid;
    bus.req_data  = vecs[n].data;
    bus.out_ready = vecs[n].ordy;
    #1;
    check($sformatf("v%0d req_ready", n), 32'(bus.req_ready), 32'(vecs[n].exp_ready));
    @(posedge clk);
    #1;
    check($sformatf("v%0d out_valid", n), 32'(bus.out_valid), 32'(vecs[n].exp_ovalid));
    if (vecs[n].exp_ovalid) begin
      check($sformatf("v%0d out_grant", n), 32'(bus.out_grant), 32'(vecs[n].exp_grant));
      check($sformatf("v%0d out_data", n), 32'(bus.out_data), 32'(vecs[n].exp_data));
    end
    check($sformatf("v%0d busy_cycles", n), 32'(bus.busy_cycles), 32'(vecs[n].exp_busy));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nvec   = 0;

    // idle after reset
    for (int i = 0; i < 5; i++) add(4'b0000, D, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd0);
    // all valid: 0,1,2,3,0 back to back
    add(4'b1111, D, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 16'd0);
    add(4'b1111, D, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 16'd0);
    add(4'b1111, D, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 16'd0);
    add(4'b1111, D, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 16'd0);
    add(4'b1111, D, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 16'd0);
    // sparse: 1,3,1,3 (ptr starts at 1)
    add(4'b1010, D, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 16'd0);
    add(4'b1010, D, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 16'd0);
    add(4'b1010, D, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 16'd0);
    add(4'b1010, D, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 16'd0);
    add(4'b0000, D, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd0);
    // op from requester 2, stalled 3 cycles while requester 0 waits
    add(4'b0100, D, 1'b0, 4'b0100, 1'b1, 2'd2, 8'hA2, 16'd0);
    add(4'b0001, D, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2, 16'd1);
    add(4'b0001, D, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2, 16'd2);
    add(4'b0001, D, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2, 16'd3);
    add(4'b0000, D, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd3);
    // drain and load on the same edge, new data for requester 0
    add(4'b0001, D, 1'b0, 4'b0001, 1'b1, 2'd0, 8'hA0, 16'd3);
    add(4'b0001, 32'hA3A2A155, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h55, 16'd3);
    add(4'b0000, D, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 16'd3);

    // reset state, with requests pending to prove nothing is consumed
    rst           = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = D;
    bus.out_ready = 1'b1;
    #12;
    check("rst req_ready", 32'(bus.req_ready), 32'h0);
    check("rst out_valid", 32'(bus.out_valid), 32'h0);
    check("rst out_data", 32'(bus.out_data), 32'h0);
    check("rst out_grant", 32'(bus.out_grant), 32'h0);
    check("rst busy_cycles", 32'(bus.busy_cycles), 32'h0);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < nvec; n++) run_vec(n);

    // async reset mid-stall (ptr is 1 here; load requester 1 so ptr moves to 2)
    @(negedge clk);
    bus.req_valid = 4'b0010;
    bus.req_data  = D;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre-rst out_grant", 32'(bus.out_grant), 32'd1);
    bus.req_valid = 4'b0000;
    @(posedge clk);
    #2;
    check("pre-rst out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("async out_valid", 32'(bus.out_valid), 32'd0);
    check("async busy_cycles", 32'(bus.busy_cycles), 32'd0);
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    check("async req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post-rst req_ready", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post-rst out_grant", 32'(bus.out_grant), 32'd0);
    check("post-rst out_data", 32'(bus.out_data), 32'hA0);
    check("post-rst out_valid", 32'(bus.out_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
